// File: rtl/sine_frame_rx.sv
// -----------------------------------------------------------------------------
// sine_frame_rx
//
// Module-side decoder for the two-byte sine-sample frame broadcast by the main
// FPGA over UART. It sits directly behind a uart_rx instance in the same clock
// domain.
//
// Frame layout:
//   byte 1 : sin_index[11:4]
//   byte 2 : {sin_index[3:0], uart_id[3:0]}
// The sin_index PIPE_CODE combined with id 4'hA is the pipe-mode command.
//
// Optional feature macro:
//   SINE_FRAME_ID_FILTER_EN - when defined, only frames whose id equals
//                             MODULE_ID update sin_index/frame_id. When it is
//                             undefined, every well-formed non-pipe frame is
//                             accepted and the consumer filters on frame_id.
//
// Ports:
//   clk          in   1  : clock, shared with the feeding uart_rx
//   reset        in   1  : asynchronous reset, active low
//   rx_data      in   8  : received byte
//   rx_done      in   1  : byte-complete strobe (pulse or level)
//   parity_error in   1  : parity flag, qualified by the rx_done rising edge
//   sin_index    out 12  : last accepted sample, held between frames
//   frame_id     out  4  : id field of the last accepted frame
//   frame_valid  out  1  : one-cycle pulse when a new sample/id is presented
//   pipe_req     out  1  : one-cycle pulse on the pipe-mode command
//   frame_error  out  1  : one-cycle pulse on parity error or inter-byte timeout
//   err_count    out  8  : saturating count of frame_error pulses
// -----------------------------------------------------------------------------
module sine_frame_rx #(
    parameter logic [3:0]  MODULE_ID      = 4'h1,
    parameter logic [11:0] PIPE_CODE      = 12'hFFF,
    parameter int unsigned TIMEOUT_CYCLES = 4800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    input  logic        parity_error,
    output logic [11:0] sin_index,
    output logic [3:0]  frame_id,
    output logic        frame_valid,
    output logic        pipe_req,
    output logic        frame_error,
    output logic [7:0]  err_count
);

`ifdef SINE_FRAME_ID_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    localparam logic [3:0] PIPE_ID = 4'hA;
    localparam int         CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic {
        WAIT_HI,
        WAIT_LO
    } state_t;

    // -------------------------------------------------------------------------
    // Byte strobe: registered rising-edge detect on rx_done. The byte and its
    // parity flag are captured alongside the strobe so the FSM sees a
    // consistent triple one cycle after the edge.
    // -------------------------------------------------------------------------
    logic       rx_done_q;
    logic       strobe;
    logic [7:0] byte_q;
    logic       byte_bad;

    // NOTE: every sequential block uses non-blocking (<=) assignments so all
    // registers update together from values sampled at the same clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_done_q <= 1'b0;
            strobe    <= 1'b0;
            byte_q    <= 8'h00;
            byte_bad  <= 1'b0;
        end else begin
            rx_done_q <= rx_done;
            strobe    <= rx_done & ~rx_done_q;
            byte_q    <= rx_data;
            byte_bad  <= parity_error;
        end
    end

    // -------------------------------------------------------------------------
    // Frame FSM
    // -------------------------------------------------------------------------
    state_t           state, state_next;
    logic [7:0]       hi, hi_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [11:0]      sin_next;
    logic [3:0]       id_next;
    logic             valid_next;
    logic             pipe_next;
    logic             err_next;

    logic [11:0] cand_index;
    logic [3:0]  cand_id;
    logic        id_ok;
    logic        is_pipe;

    assign cand_index = {hi, byte_q[7:4]};
    assign cand_id    = byte_q[3:0];
    assign id_ok      = !FILTER_EN || (cand_id == MODULE_ID);
    assign is_pipe    = (cand_id == PIPE_ID) && (cand_index == PIPE_CODE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= WAIT_HI;
            hi          <= 8'h00;
            cnt         <= '0;
            sin_index   <= 12'h000;
            frame_id    <= 4'h0;
            frame_valid <= 1'b0;
            pipe_req    <= 1'b0;
            frame_error <= 1'b0;
            err_count   <= 8'h00;
        end else begin
            state       <= state_next;
            hi          <= hi_next;
            cnt         <= cnt_next;
            sin_index   <= sin_next;
            frame_id    <= id_next;
            frame_valid <= valid_next;
            pipe_req    <= pipe_next;
            frame_error <= err_next;
            if (err_next && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'h01;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case/if tree leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        hi_next    = hi;
        cnt_next   = cnt;
        sin_next   = sin_index;
        id_next    = frame_id;
        valid_next = 1'b0;
        pipe_next  = 1'b0;
        err_next   = 1'b0;

        case (state)
            WAIT_HI: begin
                if (strobe) begin
                    if (byte_bad) begin
                        err_next = 1'b1;
                    end else begin
                        hi_next    = byte_q;
                        cnt_next   = '0;
                        state_next = WAIT_LO;
                    end
                end
            end

            WAIT_LO: begin
                // A strobe wins over the timeout, including in the cycle the
                // counter has just reached its limit.
                if (strobe) begin
                    state_next = WAIT_HI;
                    if (byte_bad) begin
                        err_next = 1'b1;
                    end else if (is_pipe) begin
                        pipe_next = 1'b1;
                    end else if (id_ok) begin
                        sin_next   = cand_index;
                        id_next    = cand_id;
                        valid_next = 1'b1;
                    end
                end else if (cnt == CNT_MAX) begin
                    err_next   = 1'b1;
                    state_next = WAIT_HI;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_sine_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_sine_frame_rx
//
// Directed testbench for sine_frame_rx (MODULE_ID = 3, default PIPE_CODE and
// TIMEOUT_CYCLES). Expectations for the id-filter case follow the
// SINE_FRAME_ID_FILTER_EN macro so the bench works with either build.
// -----------------------------------------------------------------------------
module tb_sine_frame_rx;

    localparam int unsigned TMO = 4800;

`ifdef SINE_FRAME_ID_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        parity_error;
    logic [11:0] sin_index;
    logic [3:0]  frame_id;
    logic        frame_valid;
    logic        pipe_req;
    logic        frame_error;
    logic [7:0]  err_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] exp_sin;
    logic [3:0]  exp_id;
    logic [7:0]  exp_cnt;

    sine_frame_rx #(
        .MODULE_ID      (4'h3),
        .PIPE_CODE      (12'hFFF),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .parity_error (parity_error),
        .sin_index    (sin_index),
        .frame_id     (frame_id),
        .frame_valid  (frame_valid),
        .pipe_req     (pipe_req),
        .frame_error  (frame_error),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one byte with rx_done high for a single cycle.
    task automatic send_byte(input logic [7:0] data, input logic perr);
        @(posedge clk) #1;
        rx_data      = data;
        parity_error = perr;
        rx_done      = 1'b1;
        @(posedge clk) #1;
        rx_done      = 1'b0;
        parity_error = 1'b0;
    endtask

    // Sends a byte and then samples the cycle where the result pulses appear.
    task automatic send_and_look(input logic [7:0] data, input logic perr);
        send_byte(data, perr);
        @(posedge clk) #1;
    endtask

    task automatic check_flags(input string tag, input logic v, input logic p, input logic e);
        check({tag, ".valid"}, 32'(frame_valid), 32'(v));
        check({tag, ".pipe"},  32'(pipe_req),    32'(p));
        check({tag, ".error"}, 32'(frame_error), 32'(e));
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".sin"},  32'(sin_index), 32'(exp_sin));
        check({tag, ".id"},   32'(frame_id),  32'(exp_id));
        check({tag, ".ecnt"}, 32'(err_count), 32'(exp_cnt));
    endtask

    initial begin
        int pulses;

        reset        = 1'b0;
        rx_data      = 8'h00;
        rx_done      = 1'b0;
        parity_error = 1'b0;
        exp_sin      = 12'h000;
        exp_id       = 4'h0;
        exp_cnt      = 8'h00;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check_flags("reset", 1'b0, 1'b0, 1'b0);
        check_outputs("reset");
        reset = 1'b1;

        // ---------------- basic frame AB, C3 ----------------
        send_byte(8'hAB, 1'b0);
        send_and_look(8'hC3, 1'b0);
        exp_sin = 12'hABC;
        exp_id  = 4'h3;
        check_flags("abc", 1'b1, 1'b0, 1'b0);
        check_outputs("abc");
        @(posedge clk) #1;
        check("abc.one_cycle", 32'(frame_valid), 32'd0);

        // ---------------- id 5: filtered or accepted ----------------
        send_byte(8'h12, 1'b0);
        send_and_look(8'h35, 1'b0);
        if (!FILT) begin
            exp_sin = 12'h123;
            exp_id  = 4'h5;
        end
        check_flags("id5", !FILT, 1'b0, 1'b0);
        check_outputs("id5");

        // ---------------- pipe command ----------------
        send_byte(8'hFF, 1'b0);
        send_and_look(8'hFA, 1'b0);
        check_flags("pipe", 1'b0, 1'b1, 1'b0);
        check_outputs("pipe");
        @(posedge clk) #1;
        check("pipe.one_cycle", 32'(pipe_req), 32'd0);

        // ---------------- inter-byte timeout ----------------
        // Byte 1 is latched one edge after send_byte returns; the error must
        // show TMO+1 edges after that.
        send_byte(8'h55, 1'b0);
        repeat (TMO + 1) @(posedge clk);
        #1;
        check("tmo.early", 32'(frame_error), 32'd0);
        @(posedge clk) #1;
        exp_cnt = 8'd1;
        check_flags("tmo", 1'b0, 1'b0, 1'b1);
        check_outputs("tmo");

        send_byte(8'h40, 1'b0);
        send_and_look(8'h03, 1'b0);
        exp_sin = 12'h400;
        exp_id  = 4'h3;
        check_flags("after_tmo", 1'b1, 1'b0, 1'b0);
        check_outputs("after_tmo");

        // ---------------- byte 2 strobe exactly at the timeout limit ----------------
        send_byte(8'h7E, 1'b0);
        repeat (TMO - 1) @(posedge clk);
        send_and_look(8'h93, 1'b0);
        exp_sin = 12'h7E9;
        exp_id  = 4'h3;
        check_flags("tmo_edge", 1'b1, 1'b0, 1'b0);
        check_outputs("tmo_edge");
        @(posedge clk) #1;
        check("tmo_edge.no_err", 32'(frame_error), 32'd0);

        // ---------------- parity error on byte 2 ----------------
        send_byte(8'h12, 1'b0);
        send_and_look(8'h34, 1'b1);
        exp_cnt = 8'd2;
        check_flags("par2", 1'b0, 1'b0, 1'b1);
        check_outputs("par2");
        // Back in WAIT_HI: the next two bytes form a fresh frame.
        send_byte(8'h45, 1'b0);
        send_and_look(8'h63, 1'b0);
        exp_sin = 12'h456;
        check_flags("par2.next", 1'b1, 1'b0, 1'b0);
        check_outputs("par2.next");

        // ---------------- parity error on byte 1 ----------------
        send_and_look(8'hEE, 1'b1);
        exp_cnt = 8'd3;
        check_flags("par1", 1'b0, 1'b0, 1'b1);
        send_byte(8'h6C, 1'b0);
        send_and_look(8'hD3, 1'b0);
        exp_sin = 12'h6CD;
        check_flags("par1.next", 1'b1, 1'b0, 1'b0);
        check_outputs("par1.next");

        // ---------------- rx_done held high for 10 cycles ----------------
        @(posedge clk) #1;
        rx_data = 8'h9A;
        rx_done = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk) #1;
            pulses += int'(frame_valid) + int'(pipe_req) + int'(frame_error);
        end
        rx_done = 1'b0;
        check("level.pulses", 32'(pulses), 32'd0);
        send_and_look(8'hB3, 1'b0);
        exp_sin = 12'h9AB;
        check_flags("level", 1'b1, 1'b0, 1'b0);
        check_outputs("level");

        // ---------------- err_count saturation ----------------
        for (int i = 0; i < 300; i++) begin
            send_byte(8'h00, 1'b1);
        end
        repeat (3) @(posedge clk);
        #1;
        exp_cnt = 8'hFF;
        check_outputs("sat");

        // ---------------- reset mid-frame ----------------
        send_byte(8'h77, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        exp_sin = 12'h000;
        exp_id  = 4'h0;
        exp_cnt = 8'h00;
        check_flags("in_reset", 1'b0, 1'b0, 1'b0);
        check_outputs("in_reset");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk) #1;
        check_flags("post_reset", 1'b0, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0);
        send_and_look(8'h23, 1'b0);
        exp_sin = 12'h012;
        exp_id  = 4'h3;
        check_flags("post_reset.frame", 1'b1, 1'b0, 1'b0);
        check_outputs("post_reset.frame");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
